// File: rtl/mem_lsu.sv
// mem_lsu: multi-cycle MEM-stage load/store unit with req/gnt/rvalid bus handshake,
// lane steering, load extension, misalignment and timeout exceptions.
module mem_lsu #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                op_valid,
   input  logic                op_store,
   input  logic [1:0]          op_size,
   input  logic                op_sign,
   input  logic [ADDR_W-1:0]   op_addr,
   input  logic [DATA_W-1:0]   op_wdata,
   input  logic [4:0]          op_rd,
   input  logic [31:0]         op_pc,
   output logic                stall,
   output logic                wb_valid,
   output logic [4:0]          wb_rd,
   output logic [DATA_W-1:0]   wb_data,
   output logic                exc_valid,
   output logic [1:0]          exc_code,
   output logic [31:0]         exc_pc,
   output logic                bus_req,
   output logic                bus_we,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W/8-1:0] bus_be,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_gnt,
   input  logic                bus_rvalid,
   input  logic [DATA_W-1:0]   bus_rdata
);
   localparam int NB = DATA_W / 8;
   localparam int LW = $clog2(NB);
   localparam int CW = $clog2(TIMEOUT) + 1;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   state_t          state;
   logic [CW-1:0]   cnt;
   logic            st, sg, aligned, tmo;
   logic [1:0]      sz;
   logic [LW-1:0]   off, off_q;
   logic [3:0]      nbytes;
   logic [6:0]      nbits;
   logic [NB-1:0]   be;
   logic [DATA_W-1:0] sh, mask, ld;
   always_comb begin
      off     = op_addr[LW-1:0];
      nbytes  = 4'd1 << op_size;
      aligned = (int'(op_size) <= LW) && ((off & LW'(nbytes - 4'd1)) == '0);
      be      = ((NB'(1) << nbytes) - NB'(1)) << off;
      nbits   = 7'd8 << sz;
      sh      = bus_rdata >> {off_q, 3'b000};
      mask    = (DATA_W'(1) << nbits) - DATA_W'(1);
      // the top bit of mask selects the sign bit of the access
      ld      = (sh & mask) | ((sg && |(sh & (mask ^ (mask >> 1)))) ? ~mask : '0);
      tmo     = cnt == CW'(TIMEOUT - 1);
      stall   = reset && ((state == IDLE && op_valid) || state == REQ || state == WAIT);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         st        <= 1'b0;
         sg        <= 1'b0;
         sz        <= '0;
         off_q     <= '0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         exc_valid <= 1'b0;
         exc_code  <= '0;
         exc_pc    <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= '0;
         bus_wdata <= '0;
      end else begin
         wb_valid  <= 1'b0;
         exc_valid <= 1'b0;
         case (state)
            IDLE: if (op_valid) begin
               st     <= op_store;
               sz     <= op_size;
               sg     <= op_sign;
               off_q  <= off;
               wb_rd  <= op_rd;
               exc_pc <= op_pc;
               cnt    <= '0;
               if (aligned) begin
                  state     <= REQ;
                  bus_req   <= 1'b1;
                  bus_we    <= op_store;
                  bus_addr  <= {op_addr[ADDR_W-1:LW], {LW{1'b0}}};
                  bus_be    <= op_store ? be : '0;
                  bus_wdata <= op_wdata << {off, 3'b000};
               end else begin
                  state     <= DONE;
                  exc_valid <= 1'b1;
                  exc_code  <= op_store ? 2'd2 : 2'd1;
               end
            end
            REQ: begin
               cnt <= cnt + 1'b1;
               // a timeout abandons a grant arriving in the same cycle
               if (tmo) begin
                  bus_req   <= 1'b0;
                  state     <= DONE;
                  exc_valid <= 1'b1;
                  exc_code  <= 2'd3;
               end else if (bus_gnt) begin
                  bus_req <= 1'b0;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (bus_rvalid) begin
                  state    <= DONE;
                  wb_valid <= !st;
                  wb_data  <= ld;
               end else if (tmo) begin
                  state     <= DONE;
                  exc_valid <= 1'b1;
                  exc_code  <= 2'd3;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
